// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between fetch and decode: a circular buffer of
// {pc, inst} entries with registered-state-only ready and flush on redirect.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [63:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [63:0]      out_pc,
  output logic [31:0]      out_inst,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENTRY_W = 96;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef logic [ENTRY_W-1:0] entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] nxt;
    nxt = (p == LAST_PTR) ? '0 : p + 1'b1;
    return nxt;
  endfunction

  // Ready depends only on occupancy, so a full queue never accepts a push
  // even while the head is being consumed.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign head      = mem[rp];
  assign out_pc    = head[95:32];
  assign out_inst  = head[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= ptr_inc(wp);
      if (pop)  rp <= ptr_inc(rp);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entries are cleared only by reset; a flush leaves stale data that is
  // never exposed because out_valid drops with the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wp] <= {in_pc, in_inst};
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed-vector and scoreboard bench for the instruction fetch queue.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic [2:0]  count;

  int n_vec;
  int n_miss;

  if_fetch_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fl;
    logic        ord;
    logic        eov;
    logic [63:0] epc;
    logic [31:0] einst;
    logic [2:0]  ecnt;
    logic        eir;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [63:0] pc, input logic [31:0] inst,
                     input logic fl, input logic ord, input logic eov,
                     input logic [63:0] epc, input logic [31:0] einst,
                     input logic [2:0] ecnt, input logic eir);
    vec_t v;
    v.iv = iv; v.pc = pc; v.inst = inst; v.fl = fl; v.ord = ord;
    v.eov = eov; v.epc = epc; v.einst = einst; v.ecnt = ecnt; v.eir = eir;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge and sample the outputs 1 ns later;
  // the next rising edge commits the cycle.
  task automatic drive(input logic iv, input logic [63:0] pc, input logic [31:0] inst,
                       input logic fl, input logic ord);
    @(negedge clk);
    in_valid = iv; in_pc = pc; in_inst = inst; flush = fl; out_ready = ord;
    #1;
  endtask

  logic [63:0] m_pc[$];
  logic [31:0] m_inst[$];

  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;

    #3;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_pc",    out_pc,             64'd0);
    chk("rst_out_inst",  {32'd0, out_inst},  64'd0);
    chk("rst_count",     {61'd0, count},     64'd0);
    #9 rst = 1'b1;

    // iv, pc, inst, fl, ord | eov, epc, einst, ecnt, eir
    add(0, 64'h0,         32'h0,  0, 0, 0, 64'h0,         32'h0,  3'd0, 1);
    add(1, 64'h80000000,  32'hA0, 0, 0, 0, 64'h0,         32'h0,  3'd0, 1);
    add(1, 64'h80000004,  32'hA1, 0, 0, 1, 64'h80000000,  32'hA0, 3'd1, 1);
    add(1, 64'h80000008,  32'hA2, 0, 0, 1, 64'h80000000,  32'hA0, 3'd2, 1);
    add(1, 64'h8000000C,  32'hA3, 0, 0, 1, 64'h80000000,  32'hA0, 3'd3, 1);
    add(1, 64'h80000010,  32'hA4, 0, 0, 1, 64'h80000000,  32'hA0, 3'd4, 0);
    add(0, 64'h0,         32'h0,  0, 1, 1, 64'h80000000,  32'hA0, 3'd4, 0);
    add(0, 64'h0,         32'h0,  0, 1, 1, 64'h80000004,  32'hA1, 3'd3, 1);
    add(0, 64'h0,         32'h0,  0, 1, 1, 64'h80000008,  32'hA2, 3'd2, 1);
    add(0, 64'h0,         32'h0,  0, 1, 1, 64'h8000000C,  32'hA3, 3'd1, 1);
    add(0, 64'h0,         32'h0,  0, 0, 0, 64'h0,         32'h0,  3'd0, 1);
    add(1, 64'h80000100,  32'hB0, 0, 0, 0, 64'h0,         32'h0,  3'd0, 1);
    add(1, 64'h80000104,  32'hB1, 0, 0, 1, 64'h80000100,  32'hB0, 3'd1, 1);
    add(1, 64'h80000108,  32'hB2, 0, 0, 1, 64'h80000100,  32'hB0, 3'd2, 1);
    add(1, 64'h8000010C,  32'hB3, 0, 0, 1, 64'h80000100,  32'hB0, 3'd3, 1);
    add(1, 64'h80000110,  32'hB4, 0, 1, 1, 64'h80000100,  32'hB0, 3'd4, 0);
    add(1, 64'h80000110,  32'hB4, 0, 1, 1, 64'h80000104,  32'hB1, 3'd3, 1);
    add(0, 64'h0,         32'h0,  0, 1, 1, 64'h80000108,  32'hB2, 3'd3, 1);
    add(0, 64'h0,         32'h0,  0, 1, 1, 64'h8000010C,  32'hB3, 3'd2, 1);
    add(0, 64'h0,         32'h0,  0, 1, 1, 64'h80000110,  32'hB4, 3'd1, 1);
    add(0, 64'h0,         32'h0,  0, 0, 0, 64'h0,         32'h0,  3'd0, 1);
    add(1, 64'h80000200,  32'hC0, 0, 0, 0, 64'h0,         32'h0,  3'd0, 1);
    add(1, 64'h80000204,  32'hC1, 0, 0, 1, 64'h80000200,  32'hC0, 3'd1, 1);
    add(1, 64'h80000208,  32'hC2, 0, 0, 1, 64'h80000200,  32'hC0, 3'd2, 1);
    add(1, 64'h8000020C,  32'hC3, 1, 1, 1, 64'h80000200,  32'hC0, 3'd3, 1);
    add(1, 64'h80001000,  32'hD0, 0, 0, 0, 64'h0,         32'h0,  3'd0, 1);
    add(0, 64'h0,         32'h0,  0, 0, 1, 64'h80001000,  32'hD0, 3'd1, 1);
    add(0, 64'h0,         32'h0,  0, 1, 1, 64'h80001000,  32'hD0, 3'd1, 1);
    add(0, 64'h0,         32'h0,  0, 0, 0, 64'h0,         32'h0,  3'd0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].fl, vecs[i].ord);
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].eov});
      chk($sformatf("v%0d_count", i),     {61'd0, count},     {61'd0, vecs[i].ecnt});
      chk($sformatf("v%0d_in_ready", i),  {63'd0, in_ready},  {63'd0, vecs[i].eir});
      if (vecs[i].eov) begin
        chk($sformatf("v%0d_out_pc", i),   out_pc,            vecs[i].epc);
        chk($sformatf("v%0d_out_inst", i), {32'd0, out_inst}, {32'd0, vecs[i].einst});
      end
    end

    // Steady push+pop at count 2 across several pointer wraps.
    drive(1, 64'h80002000, 32'hE00, 0, 0);
    chk("pp_fill0_count", {61'd0, count}, 64'd0);
    drive(1, 64'h80002004, 32'hE01, 0, 0);
    chk("pp_fill1_count", {61'd0, count}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 64'h80002000 + 64'(4 * (i + 2)), 32'hE00 + 32'(i + 2), 0, 1);
      chk($sformatf("pp%0d_count", i),  {61'd0, count},    64'd2);
      chk($sformatf("pp%0d_out_pc", i), out_pc,            64'h80002000 + 64'(4 * i));
      chk($sformatf("pp%0d_inst", i),   {32'd0, out_inst}, {32'd0, 32'hE00 + 32'(i)});
    end
    drive(0, 64'h0, 32'h0, 0, 0);
    chk("pp_end_count", {61'd0, count}, 64'd2);

    // Asynchronous reset between edges with two entries queued.
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_count",     {61'd0, count},     64'd0);
    chk("arst_out_pc",    out_pc,             64'd0);
    chk("arst_in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    drive(1, 64'h80003000, 32'hF00, 0, 0);
    chk("post_rst_count", {61'd0, count}, 64'd0);
    drive(0, 64'h0, 32'h0, 0, 1);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_pc",    out_pc,             64'h80003000);
    drive(0, 64'h0, 32'h0, 0, 0);
    chk("post_rst_empty", {61'd0, count}, 64'd0);

    // Random traffic against a queue scoreboard.
    begin
      logic [63:0] npc;
      logic iv, ord, fl, push, pop;
      npc = 64'h80010000;
      for (int c = 0; c < 400; c++) begin
        iv  = 1'($urandom_range(0, 1));
        ord = 1'($urandom_range(0, 1));
        fl  = ($urandom_range(0, 15) == 0);
        drive(iv, npc, npc[31:0] ^ 32'h5A5A0000, fl, ord);
        chk("rnd_count",     {61'd0, count},     64'(m_pc.size()));
        chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, m_pc.size() != 0});
        chk("rnd_in_ready",  {63'd0, in_ready},  {63'd0, m_pc.size() != 4});
        if (m_pc.size() != 0) begin
          chk("rnd_out_pc",   out_pc,            m_pc[0]);
          chk("rnd_out_inst", {32'd0, out_inst}, {32'd0, m_inst[0]});
        end
        push = iv && (m_pc.size() < 4) && !fl;
        pop  = ord && (m_pc.size() != 0) && !fl;
        if (fl) begin
          m_pc.delete();
          m_inst.delete();
          npc = npc + 64'h100;
        end else begin
          if (pop) begin
            void'(m_pc.pop_front());
            void'(m_inst.pop_front());
          end
          if (push) begin
            m_pc.push_back(npc);
            m_inst.push_back(npc[31:0] ^ 32'h5A5A0000);
            npc = npc + 64'd4;
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
